// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO over a dual-port array with occupancy and programmable almost flags.
// Define SYNC_FIFO_ERR_EN to add registered overflow/underflow pulse outputs.
module sync_fifo_mem #(
   parameter int unsigned DATASIZE    = 8,
   parameter int unsigned ADDRSIZE    = 4,
   parameter string       FALLTHROUGH = "TRUE",
   parameter int unsigned AFULL_TH    = (1 << ADDRSIZE) - 1,
   parameter int unsigned AEMPTY_TH   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATASIZE-1:0] wdata,
   input  logic                winc,
   output logic                wfull,
   output logic                awfull,
   input  logic                rinc,
   output logic [DATASIZE-1:0] rdata,
   output logic                rempty,
   output logic                arempty,
`ifdef SYNC_FIFO_ERR_EN
   output logic                overflow,
   output logic                underflow,
`endif
   output logic [ADDRSIZE:0]   level
);

   localparam int unsigned DEPTH = 1 << ADDRSIZE;
   localparam int unsigned PW    = ADDRSIZE + 1;
   localparam bit          FWFT  = (FALLTHROUGH == "TRUE");

   logic [DATASIZE-1:0] mem [DEPTH];
   logic [PW-1:0]       wptr, rptr;
   logic [PW-1:0]       wptr_nxt, rptr_nxt, level_nxt;
   logic                wr_ok, rd_ok;

   // Accept decisions use the flags registered at the start of the cycle.
   always_comb begin
      wr_ok     = winc && !wfull;
      rd_ok     = rinc && !rempty;
      wptr_nxt  = wptr + PW'(wr_ok);
      rptr_nxt  = rptr + PW'(rd_ok);
      level_nxt = wptr_nxt - rptr_nxt;
   end

   // Pointers, level and flags; flags follow the next level so they agree with level.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         level   <= '0;
         wfull   <= 1'b0;
         rempty  <= 1'b1;
         awfull  <= (AFULL_TH == 0);
         arempty <= 1'b1;
      end else begin
         wptr    <= wptr_nxt;
         rptr    <= rptr_nxt;
         level   <= level_nxt;
         wfull   <= (level_nxt == PW'(DEPTH));
         rempty  <= (level_nxt == '0);
         awfull  <= (level_nxt >= PW'(AFULL_TH));
         arempty <= (level_nxt <= PW'(AEMPTY_TH));
      end
   end

   // Storage is never reset.
   always_ff @(posedge clk) begin
      if (wr_ok && !rst)
         mem[wptr[ADDRSIZE-1:0]] <= wdata;
   end

   if (FWFT) begin : g_fwft
      assign rdata = mem[rptr[ADDRSIZE-1:0]];
   end else begin : g_reg
      always_ff @(posedge clk) begin
         if (rst)
            rdata <= '0;
         else if (rd_ok)
            rdata <= mem[rptr[ADDRSIZE-1:0]];
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   // One pulse per rejected request, back-to-back if requests repeat.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= winc && wfull;
         underflow <= rinc && rempty;
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_mem.sv
// Directed bench: 4-deep fall-through instance and 16-deep registered-read instance.
module tb_sync_fifo_mem;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] a_wdata, a_rdata, b_wdata, b_rdata;
   logic       a_winc, a_rinc, a_wfull, a_awfull, a_rempty, a_arempty;
   logic       b_winc, b_rinc, b_wfull, b_awfull, b_rempty, b_arempty;
   logic [2:0] a_level;
   logic [4:0] b_level;
`ifdef SYNC_FIFO_ERR_EN
   logic       a_overflow, a_underflow, b_overflow, b_underflow;
`endif

   int n_run  = 0;
   int n_fail = 0;

   sync_fifo_mem #(.DATASIZE(8), .ADDRSIZE(2), .FALLTHROUGH("TRUE")) u_ft (
      .clk(clk), .rst(rst), .wdata(a_wdata), .winc(a_winc), .wfull(a_wfull),
      .awfull(a_awfull), .rinc(a_rinc), .rdata(a_rdata), .rempty(a_rempty),
      .arempty(a_arempty),
`ifdef SYNC_FIFO_ERR_EN
      .overflow(a_overflow), .underflow(a_underflow),
`endif
      .level(a_level)
   );

   sync_fifo_mem #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("FALSE")) u_reg (
      .clk(clk), .rst(rst), .wdata(b_wdata), .winc(b_winc), .wfull(b_wfull),
      .awfull(b_awfull), .rinc(b_rinc), .rdata(b_rdata), .rempty(b_rempty),
      .arempty(b_arempty),
`ifdef SYNC_FIFO_ERR_EN
      .overflow(b_overflow), .underflow(b_underflow),
`endif
      .level(b_level)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input int lvl, input logic wf, input logic af,
                        input logic re, input logic ae);
      check({tag, "_level"},   32'(a_level),   32'(lvl));
      check({tag, "_wfull"},   32'(a_wfull),   32'(wf));
      check({tag, "_awfull"},  32'(a_awfull),  32'(af));
      check({tag, "_rempty"},  32'(a_rempty),  32'(re));
      check({tag, "_arempty"}, 32'(a_arempty), 32'(ae));
   endtask

   logic [7:0] q[$];
   logic [7:0] exp_rd;
   int         lvl, wr;
   logic       w_ok, r_ok;

   initial begin
      rst = 1'b1;
      a_winc = 1'b0; a_rinc = 1'b0; a_wdata = 8'h00;
      b_winc = 1'b0; b_rinc = 1'b0; b_wdata = 8'h00;
      step();
      step();
      chk_a("rst_a", 0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("rst_b_level",   32'(b_level),   32'd0);
      check("rst_b_rempty",  32'(b_rempty),  32'd1);
      check("rst_b_arempty", 32'(b_arempty), 32'd1);
      check("rst_b_wfull",   32'(b_wfull),   32'd0);
      check("rst_b_awfull",  32'(b_awfull),  32'd0);
      check("rst_b_rdata",   32'(b_rdata),   32'd0);
      rst = 1'b0;
      step();
      chk_a("idle_a", 0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Fill the 4-deep fall-through FIFO: head visible one cycle after first write.
      for (int i = 0; i < 4; i++) begin
         a_winc = 1'b1; a_wdata = 8'(8'hA1 + i);
         step();
         chk_a("fill_a", i + 1, i == 3, i >= 2, 1'b0, i == 0);
         check("fill_a_head", 32'(a_rdata), 32'hA1);
      end
      a_winc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("drain_a_data", 32'(a_rdata), 32'(8'hA1 + i));
         a_rinc = 1'b1;
         step();
         check("drain_a_level", 32'(a_level), 32'(3 - i));
      end
      a_rinc = 1'b0;
      chk_a("drained_a", 0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef SYNC_FIFO_ERR_EN
      a_rinc = 1'b1;
      step();
      check("underflow_pulse", 32'(a_underflow), 32'd1);
      a_rinc = 1'b0;
      step();
      check("underflow_clear", 32'(a_underflow), 32'd0);
      check("underflow_level", 32'(a_level), 32'd0);
`endif

      // Refill, then a rejected write and a write+read while full.
      for (int i = 0; i < 4; i++) begin
         a_winc = 1'b1; a_wdata = 8'(8'hB1 + i);
         step();
      end
      a_wdata = 8'h5A;
      step();
      chk_a("rej_write", 4, 1'b1, 1'b1, 1'b0, 1'b0);
      a_winc = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
      check("overflow_pulse", 32'(a_overflow), 32'd1);
      step();
      check("overflow_clear", 32'(a_overflow), 32'd0);
`endif
      check("rej_head", 32'(a_rdata), 32'hB1);
      a_winc = 1'b1; a_rinc = 1'b1; a_wdata = 8'h55;
      step();
      a_winc = 1'b0; a_rinc = 1'b0;
      chk_a("full_both", 3, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("full_both_data", 32'(a_rdata), 32'(8'hB2 + i));
         a_rinc = 1'b1;
         step();
      end
      a_rinc = 1'b0;
      chk_a("full_both_empty", 0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Write+read while empty: only the write lands.
      a_winc = 1'b1; a_rinc = 1'b1; a_wdata = 8'h77;
      step();
      a_winc = 1'b0; a_rinc = 1'b0;
      chk_a("empty_both", 1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("empty_both_data", 32'(a_rdata), 32'h77);

      // Reset with three entries held and a write pending.
      a_winc = 1'b1; a_wdata = 8'h81;
      step();
      step();
      chk_a("pre_rst", 3, 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0; a_winc = 1'b0;
      chk_a("mid_rst", 0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Registered instance: simultaneous on empty leaves rdata until a later read.
      b_winc = 1'b1; b_rinc = 1'b1; b_wdata = 8'h77;
      step();
      b_winc = 1'b0; b_rinc = 1'b0;
      check("b_empty_both_level", 32'(b_level), 32'd1);
      check("b_empty_both_rdata", 32'(b_rdata), 32'd0);
      step();
      check("b_hold_rdata", 32'(b_rdata), 32'd0);
      b_rinc = 1'b1;
      step();
      b_rinc = 1'b0;
      check("b_read_rdata", 32'(b_rdata), 32'h77);
      check("b_read_level", 32'(b_level), 32'd0);

      // 40 writes interleaved with reads so both pointers wrap.
      lvl = 0; wr = 0; exp_rd = 8'h77;
      for (int c = 0; c < 400 && !(wr == 40 && lvl == 0); c++) begin
         b_winc  = (wr < 40) && (c % 4 != 3);
         b_rinc  = ((c >= 12) && (c % 2 == 0)) || (wr >= 40);
         b_wdata = 8'(8'h10 + wr);
         w_ok = b_winc && (lvl != 16);
         r_ok = b_rinc && (lvl != 0);
         step();
         if (r_ok) exp_rd = q.pop_front();
         if (w_ok) begin
            q.push_back(b_wdata);
            wr++;
         end
         lvl = q.size();
         check("wrap_level",   32'(b_level),   32'(lvl));
         check("wrap_rdata",   32'(b_rdata),   32'(exp_rd));
         check("wrap_awfull",  32'(b_awfull),  32'(lvl >= 15));
         check("wrap_arempty", 32'(b_arempty), 32'(lvl <= 1));
         check("wrap_wfull",   32'(b_wfull),   32'(lvl == 16));
         check("wrap_rempty",  32'(b_rempty),  32'(lvl == 0));
      end
      b_winc = 1'b0; b_rinc = 1'b0;
      if (!(wr == 40 && lvl == 0)) begin
         n_fail++;
         $display("FAIL wrap_timeout: writes %0d level %0d not drained", wr, lvl);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
